// File: rtl/psum_accum_wb.sv
// Output stage behind the PE array: accumulates one tile row of psums across input channels,
// then quantizes (shift, optional ReLU, saturate) the last-channel sums into a drainable FIFO.
module psum_accum_wb #(
  parameter int tile_length = 16,
  parameter int PSUM_W      = 16,
  parameter int ACC_W       = 24,
  parameter int OUT_W       = 8,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_conv,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic              p_valid,
  input  logic              last_chanel,
  input  logic [PSUM_W-1:0] psum_in,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              tile_done,
  output logic              overflow
);

  localparam int AW = $clog2(tile_length);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] r_buf [tile_length];
  logic [AW-1:0]           r_addr;
  logic                    r_first;

  logic                    r_s2_valid;
  logic                    r_s2_last;
  logic                    r_s2_wrap;
  logic signed [ACC_W-1:0] r_s2_sum;

  logic                    r_s3_valid;
  logic [OUT_W-1:0]        r_s3_data;
  logic                    r_tile_done;

  logic [OUT_W-1:0]        r_mem [FIFO_DEPTH];
  logic [FW-1:0]           r_rd_ptr;
  logic [FW-1:0]           r_wr_ptr;
  logic [FW:0]             r_count;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_overflow;

  logic                    w_wrap;
  logic signed [ACC_W-1:0] w_sext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_relu;
  logic [OUT_W-1:0]        w_q;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic [FW-1:0]           w_rd_next;
  logic [FW:0]             w_count_next;
  logic [OUT_W-1:0]        w_head_next;

  assign w_wrap    = (r_addr == AW'(tile_length - 1));
  assign w_sext    = ACC_W'($signed(psum_in));
  assign w_sum     = r_first ? w_sext : r_buf[r_addr] + w_sext;

  assign w_shifted = r_s2_sum >>> cfg_shift;
  assign w_relu    = (cfg_relu && w_shifted[ACC_W-1]) ? '0 : w_shifted;
  assign w_q       = (w_relu > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                     (w_relu < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : w_relu[OUT_W-1:0];

  // Drain port: a word transfers on every cycle where out_valid and out_ready are both high;
  // out_data is held stable while out_valid is high and out_ready is low.
  assign w_full       = (r_count == (FW+1)'(FIFO_DEPTH));
  assign w_pop        = (r_count != '0) && out_ready;
  assign w_push       = r_s3_valid && (!w_full || w_pop);
  assign w_drop       = r_s3_valid && w_full && !w_pop;
  assign w_rd_next    = r_rd_ptr + FW'(w_pop);
  assign w_count_next = r_count + (FW+1)'(w_push) - (FW+1)'(w_pop);
  // The pushed word becomes the head directly when it lands on the next read slot.
  assign w_head_next  = (w_count_next == '0) ? '0 :
                        (w_push && (r_wr_ptr == w_rd_next)) ? r_s3_data : r_mem[w_rd_next];

  always_ff @(posedge clk) begin
    if (p_valid && !start_conv) r_buf[r_addr] <= w_sum;
  end

  always_ff @(posedge clk) begin
    if (w_push && !start_conv) r_mem[r_wr_ptr] <= r_s3_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || start_conv) begin
      r_addr      <= '0;
      r_first     <= 1'b1;
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_wrap   <= 1'b0;
      r_s2_sum    <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_data   <= '0;
      r_tile_done <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (p_valid) begin
        r_addr <= w_wrap ? '0 : r_addr + AW'(1);
        if (w_wrap) r_first <= last_chanel;
      end
      r_s2_valid  <= p_valid;
      r_s2_last   <= last_chanel;
      r_s2_wrap   <= w_wrap;
      r_s2_sum    <= w_sum;
      r_s3_valid  <= r_s2_valid && r_s2_last;
      r_s3_data   <= w_q;
      r_tile_done <= r_s2_valid && r_s2_last && r_s2_wrap;
      r_rd_ptr    <= w_rd_next;
      r_wr_ptr    <= r_wr_ptr + FW'(w_push);
      r_count     <= w_count_next;
      r_out_data  <= w_head_next;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_out_data;
  assign tile_done = r_tile_done;
  assign overflow  = r_overflow;

endmodule

// File: doc/psum_accum_wb.md
Name: psum_accum_wb

Overview:
Output stage directly downstream of the PE array and its sequencing FSM. Consumes the delayed partial-sum strobes (p_valid_output, last_chanel_output) and the PE psum stream. Accumulates one tile row of psums across all input channels in a tile_length-entry buffer. On the last channel it applies shift, optional ReLU and saturation, then pushes the result into an output FIFO with a valid/ready drain port.

Parameters:
tile_length, 16, psums per channel pass; accumulator buffer depth
PSUM_W, 16, signed psum input width
ACC_W, 24, signed accumulator width
OUT_W, 8, signed output width
FIFO_DEPTH, 32, output FIFO entries (power of 2, >= tile_length)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_conv  in  1  synchronous clear of all state, one-cycle pulse
cfg_shift  in  5  arithmetic right shift applied before saturation; stable during a tile
cfg_relu  in  1  1 = clamp negative results to 0
p_valid  in  1  psum_in is valid this cycle (driven by p_valid_output)
last_chanel  in  1  current sample belongs to the last input channel (driven by last_chanel_output)
psum_in  in  PSUM_W  signed partial sum
out_valid  out  1  FIFO not empty
out_data  out  OUT_W  FIFO head
out_ready  in  1  consumer accepts head
tile_done  out  1  one-cycle pulse when the last result of a tile enters the FIFO stage
overflow  out  1  sticky: a result was dropped on a full FIFO

Behaviour:
- Reset (async, rst_n=0): addr=0, first=1, pipeline valids=0, FIFO empty, out_valid=0, out_data=0, tile_done=0, overflow=0. The accumulator buffer contents are don't-care.
- start_conv=1: same clear, synchronous. It wins over a same-cycle p_valid, and that sample is dropped.
- Sample accept: each cycle with p_valid=1 is one sample at buffer index addr.
  - addr increments per sample and wraps tile_length-1 -> 0.
  - addr does not move while p_valid=0, so a burst interrupted by a gap resumes where it stopped.
- Stage 1 (registered, cycle t+1 after sample at t):
  - first=1: buf[addr] = sext(psum_in).
  - first=0: buf[addr] = buf[addr] + sext(psum_in), modulo 2^ACC_W. No saturation.
  - The new sum is also latched, with last_chanel, into the stage-2 register.
- first flag updates on the wrap sample (addr = tile_length-1):
  - If last_chanel=1 on that sample: first <= 1.
  - Otherwise: first <= 0.
  - With a single input channel (last_chanel on the first pass), every pass starts at first=1.
- Stage 2 (registered, cycle t+2), only for last_chanel=1 samples:
  - s = sum >>> cfg_shift.
  - If cfg_relu and s<0: s=0.
  - Saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Push s into the FIFO.
  - Total latency: sample at t -> out_valid at t+3 if the FIFO was empty.
- tile_done: pulses at t+2 for the sample that had addr=tile_length-1 and last_chanel=1. It pulses even if that push is dropped.
- No read-after-write hazard: consecutive accesses to the same addr are at least tile_length >= 2 samples apart.
- FIFO:
  - out_valid = count != 0; out_data = head entry, registered.
  - Pop on out_valid & out_ready.
  - Push with FIFO full and a same-cycle pop: accepted, count unchanged.
  - Push with FIFO full and no pop: result dropped, overflow <= 1 until reset/start_conv.
  - Pop on empty: ignored.
- last_chanel with p_valid=0 is ignored. Mixed last_chanel within one pass is applied per sample, as sampled.

Test Plan:
1. Reset mid-burst: drive 5 samples, assert rst_n=0 -> all outputs 0 immediately; next pass re-starts at addr 0 with first=1.
2. Single channel: tile_length=16, cfg_shift=0, cfg_relu=0, psum_in=i (0..15), last_chanel=1 throughout -> out_data sequence 0..15; first out_valid 3 cycles after the first sample; tile_done once, 2 cycles after the 16th sample.
3. Eight channels, psum_in=10 each sample, 4-cycle gaps between passes, last_chanel on pass 8 only -> 16 outputs of 80; no output during passes 1-7. A second tile with psum_in=1 gives 8 (checks first-flag reload).
4. Quantize corners:
   - sum 1000, shift 2 -> 127 (saturated).
   - sum -1000, relu=0, shift 2 -> -128.
   - sum -1000, relu=1 -> 0.
   - sum 300, shift 3 -> 37.
5. Backpressure: out_ready=0, FIFO_DEPTH=32, three single-channel tiles (48 results) -> 32 held, overflow=1 after the 33rd push. Then out_ready=1 drains exactly 32 values in order.
6. Full+pop same cycle: FIFO full, out_ready=1 on the push cycle -> no drop, overflow stays 0. start_conv mid-tile -> FIFO empty, addr=0, overflow=0 next cycle.
